acr_packet_generator: RTL and testbench

ACR_PACKET_GENERATOR -- requirements
Module: acr_packet_generator

---
 rtl/acr_pkg.sv | 60 ++++++
 rtl/sync_edge_detect.sv | 28 ++
 rtl/acr_packet_generator.sv | 172 +++++++++++++++++
 tb/tb_acr_packet_generator.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acr_pkg.sv
// Shared types and constants for the ACR packet generator.
// Holds rate/state enums, N and divider lookups and the packet field packer.
package acr_pkg;

    typedef enum logic [1:0] {
        RATE_32K  = 2'd0,
        RATE_44K1 = 2'd1,
        RATE_48K  = 2'd2,
        RATE_96K  = 2'd3
    } rate_e;

    typedef enum logic [1:0] {
        ST_ALIGN   = 2'd0,
        ST_MEASURE = 2'd1,
        ST_STALL   = 2'd2
    } acr_state_e;

    localparam logic [19:0] N_32K  = 20'd4096;
    localparam logic [19:0] N_44K1 = 20'd6272;
    localparam logic [19:0] N_48K  = 20'd6144;
    localparam logic [19:0] N_96K  = 20'd12288;

    // Audio ticks per ACR period (N/128)
    localparam logic [6:0] DIV_32K  = 7'd32;
    localparam logic [6:0] DIV_44K1 = 7'd49;
    localparam logic [6:0] DIV_48K  = 7'd48;
    localparam logic [6:0] DIV_96K  = 7'd96;

    localparam logic [23:0] ACR_HEADER = {8'd0, 8'd0, 8'd1};

    function automatic logic [19:0] n_lookup(input rate_e r);
        logic [19:0] n;
        case (r)
            RATE_32K:  n = N_32K;
            RATE_44K1: n = N_44K1;
            RATE_48K:  n = N_48K;
            default:   n = N_96K;
        endcase
        return n;
    endfunction

    function automatic logic [6:0] div_lookup(input rate_e r);
        logic [6:0] d;
        case (r)
            RATE_32K:  d = DIV_32K;
            RATE_44K1: d = DIV_44K1;
            RATE_48K:  d = DIV_48K;
            default:   d = DIV_96K;
        endcase
        return d;
    endfunction

    // Little-endian byte order inside each subpacket, high nibbles padded
    function automatic logic [55:0] pack_sub(input logic [19:0] n,
                                             input logic [19:0] cts);
        return {n[7:0], n[15:8], 4'd0, n[19:16],
                cts[7:0], cts[15:8], 4'd0, cts[19:16], 8'd0};
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser followed by a rising-edge detector.
// Ports: clk/rst_n (async low), async_in (foreign domain), tick (1-cycle pulse).
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic tick
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign tick = sync2_q & ~prev_q;

endmodule

// File: rtl/acr_packet_generator.sv
// Measures pixel clocks per N/128 audio ticks and emits HDMI ACR packets.
// Ports: clk_pixel/reset_n, clk_audio, rate_sel, pkt_ready/pkt_valid, header, sub, locked, overrun.
module acr_packet_generator
    import acr_pkg::*;
#(
    parameter int VIDEO_RATE     = 27000000,
    parameter int CTS_WIDTH      = 20,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clk_pixel,
    input  logic              reset_n,
    input  logic              clk_audio,
    input  logic [1:0]        rate_sel,
    input  logic              pkt_ready,
    output logic              pkt_valid,
    output logic [23:0]       header,
    output logic [3:0][55:0]  sub,
    output logic              locked,
    output logic              overrun
);

    // A CTS can never exceed one second of pixel clocks, nor the field width
    localparam int CTS_FULL = (1 << CTS_WIDTH) - 1;
    localparam int CTS_CAP  = (VIDEO_RATE < CTS_FULL) ? VIDEO_RATE : CTS_FULL;
    localparam logic [CTS_WIDTH-1:0] CTS_MAX = CTS_CAP[CTS_WIDTH-1:0];

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic tick;

    acr_state_e           state_q, state_d;
    logic [CTS_WIDTH-1:0] cnt_q, cnt_d;
    logic [6:0]           div_q, div_d;
    logic [IDLE_W-1:0]    idle_q, idle_d;
    logic [CTS_WIDTH-1:0] cts_q, cts_d;
    logic [19:0]          n_q, n_d;
    logic [1:0]           rate_q, rate_d;
    logic                 pkt_valid_q, pkt_valid_d;
    logic                 locked_q, locked_d;
    logic                 overrun_q, overrun_d;

    logic                 rate_chg;
    logic [CTS_WIDTH-1:0] cnt_inc;
    logic [6:0]           div_last;
    logic [19:0]          cts_ext;
    logic [55:0]          sub_word;

    sync_edge_detect u_sync (
        .clk      (clk_pixel),
        .rst_n    (reset_n),
        .async_in (clk_audio),
        .tick     (tick)
    );

    always_comb begin
        rate_chg = (rate_sel != rate_q);
        cnt_inc  = (cnt_q == CTS_MAX) ? CTS_MAX : cnt_q + CTS_WIDTH'(1);
        div_last = div_lookup(rate_e'(rate_q)) - 7'd1;

        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        idle_d      = idle_q;
        cts_d       = cts_q;
        n_d         = n_q;
        rate_d      = rate_sel;
        pkt_valid_d = pkt_valid_q;
        locked_d    = locked_q;
        overrun_d   = overrun_q;

        if (pkt_valid_q && pkt_ready) begin
            pkt_valid_d = 1'b0;
        end

        if (rate_chg) begin
            // Rate switch outranks everything: restart from scratch
            state_d     = ST_ALIGN;
            cnt_d       = '0;
            div_d       = '0;
            idle_d      = '0;
            locked_d    = 1'b0;
            pkt_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_ALIGN: begin
                    cnt_d  = '0;
                    div_d  = '0;
                    idle_d = '0;
                    if (tick) begin
                        state_d = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    cnt_d = cnt_inc;
                    if (tick) begin
                        idle_d = '0;
                        if (div_q == div_last) begin
                            cnt_d       = '0;
                            div_d       = '0;
                            cts_d       = cnt_inc;
                            n_d         = n_lookup(rate_e'(rate_q));
                            locked_d    = 1'b1;
                            pkt_valid_d = 1'b1;
                            if (pkt_valid_q && !pkt_ready) begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            div_d = div_q + 7'd1;
                        end
                    end else if (idle_q == IDLE_LAST) begin
                        state_d     = ST_STALL;
                        idle_d      = '0;
                        locked_d    = 1'b0;
                        pkt_valid_d = 1'b0;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
                ST_STALL: begin
                    // Restart tick only re-arms alignment
                    if (tick) begin
                        state_d = ST_ALIGN;
                    end
                end
                default: begin
                    state_d = ST_ALIGN;
                end
            endcase
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_ALIGN;
            cnt_q       <= '0;
            div_q       <= '0;
            idle_q      <= '0;
            cts_q       <= '0;
            n_q         <= '0;
            rate_q      <= rate_sel;
            pkt_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            idle_q      <= idle_d;
            cts_q       <= cts_d;
            n_q         <= n_d;
            rate_q      <= rate_d;
            pkt_valid_q <= pkt_valid_d;
            locked_q    <= locked_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        cts_ext  = 20'(cts_q);
        sub_word = pack_sub(n_q, cts_ext);
        for (int i = 0; i < 4; i++) begin
            sub[i] = sub_word;
        end
    end

    assign header    = ACR_HEADER;
    assign pkt_valid = pkt_valid_q;
    assign locked    = locked_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_acr_packet_generator.sv
// Directed bench for acr_packet_generator.
// Drives a pixel clock and a programmable audio clock; checks packet fields.
module tb_acr_packet_generator;

    logic             clk_pixel = 1'b0;
    logic             reset_n;
    logic             clk_audio;
    logic [1:0]       rate_sel;
    logic             pkt_ready;

    logic             pkt_valid, locked, overrun;
    logic [23:0]      header;
    logic [3:0][55:0] sub;

    logic             pkt_valid12, locked12, overrun12;
    logic [23:0]      header12;
    logic [3:0][55:0] sub12;

    int n_cmp = 0;
    int n_bad = 0;
    int aud_per = 0;
    int aud_edges = 0;
    int base = 0;
    int ph = 0;
    int last_per = 0;

    acr_packet_generator #(.TIMEOUT_CYCLES(3000)) dut (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .clk_audio (clk_audio),
        .rate_sel  (rate_sel),
        .pkt_ready (pkt_ready),
        .pkt_valid (pkt_valid),
        .header    (header),
        .sub       (sub),
        .locked    (locked),
        .overrun   (overrun)
    );

    acr_packet_generator #(.CTS_WIDTH(12)) dut12 (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .clk_audio (clk_audio),
        .rate_sel  (rate_sel),
        .pkt_ready (pkt_ready),
        .pkt_valid (pkt_valid12),
        .header    (header12),
        .sub       (sub12),
        .locked    (locked12),
        .overrun   (overrun12)
    );

    always #5 clk_pixel = ~clk_pixel;

    // Audio clock with a period of aud_per pixel cycles; 0 stops it low.
    // A period change mid-run restarts timing from the most recent rise.
    initial begin
        clk_audio = 1'b0;
        forever begin
            @(negedge clk_pixel);
            if (aud_per == 0) begin
                ph = 0;
                last_per = 0;
                clk_audio = 1'b0;
            end else begin
                if (aud_per != last_per)
                    ph = (last_per == 0) ? 0 : aud_per / 2 + 1;
                else
                    ph = (ph + 1 >= aud_per) ? 0 : ph + 1;
                last_per = aud_per;
                clk_audio = (ph >= aud_per / 2);
            end
        end
    end

    always @(posedge clk_audio) aud_edges <= aud_edges + 1;

    task automatic chk(input string tag, input logic [223:0] got,
                       input logic [223:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [55:0] mk_sub(input int n, input int cts);
        logic [19:0] nn;
        logic [19:0] cc;
        nn = n[19:0];
        cc = cts[19:0];
        return {nn[7:0], nn[15:8], 4'd0, nn[19:16],
                cc[7:0], cc[15:8], 4'd0, cc[19:16], 8'd0};
    endfunction

    function automatic logic [223:0] rep4(input logic [55:0] w);
        return {w, w, w, w};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_pixel);
        #1;
    endtask

    task automatic wait_edges(input int n, input int budget);
        int k;
        k = 0;
        while ((aud_edges - base) < n && k < budget) begin
            @(posedge clk_pixel);
            k++;
        end
        if ((aud_edges - base) < n)
            chk("edge_timeout", aud_edges - base, n);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] r);
        @(negedge clk_pixel);
        aud_per = 0;
        pkt_ready = 1'b0;
        reset_n = 1'b0;
        rate_sel = r;
        repeat (3) @(negedge clk_pixel);
        reset_n = 1'b1;
        base = aud_edges;
    endtask

    task automatic accept_pulse(input string tag);
        @(negedge clk_pixel);
        pkt_ready = 1'b1;
        @(posedge clk_pixel);
        #1;
        chk(tag, pkt_valid, 1'b0);
        @(negedge clk_pixel);
        pkt_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset_n = 1'b0;
        rate_sel = 2'd2;
        pkt_ready = 1'b0;
        cyc(3);
        chk("rst_valid", pkt_valid, 1'b0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_header", header, 24'h000001);
        chk("rst_sub", sub, '0);
        chk("rst_sub12", sub12, '0);

        // 48 kHz, tick every 500 cycles
        @(negedge clk_pixel);
        reset_n = 1'b1;
        base = aud_edges;
        aud_per = 500;
        wait_edges(48, 30000);
        cyc(4);
        chk("b_valid_early", pkt_valid, 1'b0);
        chk("b_locked_early", locked, 1'b0);
        wait_edges(49, 1000);
        cyc(4);
        chk("b_valid", pkt_valid, 1'b1);
        chk("b_locked", locked, 1'b1);
        chk("b_sub", sub, rep4(56'h00_18_00_C0_5D_00_00));
        chk("b_header", header, 24'h000001);
        chk("b_overrun", overrun, 1'b0);
        accept_pulse("b_accept");

        // Two latches without acceptance, second period longer
        do_reset(2'd2);
        aud_per = 20;
        wait_edges(49, 2000);
        aud_per = 30;
        cyc(4);
        chk("c_valid1", pkt_valid, 1'b1);
        chk("c_sub1", sub, rep4(mk_sub(6144, 960)));
        wait_edges(96, 3000);
        cyc(4);
        chk("c_sub_hold", sub, rep4(mk_sub(6144, 960)));
        chk("c_ovr_early", overrun, 1'b0);
        wait_edges(97, 200);
        cyc(4);
        chk("c_overrun", overrun, 1'b1);
        chk("c_valid2", pkt_valid, 1'b1);
        chk("c_sub2", sub, rep4(mk_sub(6144, 1440)));
        accept_pulse("c_accept");
        chk("c_ovr_sticky", overrun, 1'b1);

        // Reset in the middle of a measurement
        wait_edges(107, 600);
        @(negedge clk_pixel);
        reset_n = 1'b0;
        #1;
        chk("f_valid", pkt_valid, 1'b0);
        chk("f_locked", locked, 1'b0);
        chk("f_overrun", overrun, 1'b0);
        chk("f_sub", sub, '0);
        cyc(3);
        k = 0;
        while (clk_audio !== 1'b1 && k < 100) begin cyc(1); k++; end
        while (clk_audio !== 1'b0 && k < 100) begin cyc(1); k++; end
        chk("f_phase_timeout", clk_audio, 1'b0);
        @(negedge clk_pixel);
        reset_n = 1'b1;
        base = aud_edges;
        wait_edges(48, 2000);
        cyc(4);
        chk("f_no_early_pkt", pkt_valid, 1'b0);
        wait_edges(49, 200);
        cyc(4);
        chk("f_valid_new", pkt_valid, 1'b1);
        chk("f_sub_new", sub, rep4(mk_sub(6144, 1440)));

        // Audio stops for longer than the timeout
        do_reset(2'd2);
        aud_per = 20;
        wait_edges(49, 2000);
        cyc(1);
        aud_per = 0;
        cyc(2900);
        chk("d_locked_pre", locked, 1'b1);
        chk("d_valid_pre", pkt_valid, 1'b1);
        cyc(200);
        chk("d_locked_stall", locked, 1'b0);
        chk("d_valid_stall", pkt_valid, 1'b0);
        chk("d_sub_kept", sub, rep4(mk_sub(6144, 960)));
        base = aud_edges;
        aud_per = 24;
        wait_edges(49, 2000);
        cyc(4);
        chk("d_valid_early", pkt_valid, 1'b0);
        wait_edges(50, 200);
        cyc(4);
        chk("d_valid", pkt_valid, 1'b1);
        chk("d_locked", locked, 1'b1);
        chk("d_sub", sub, rep4(mk_sub(6144, 1152)));

        // Rate change 48k -> 44.1k mid-period
        do_reset(2'd2);
        aud_per = 20;
        wait_edges(49, 2000);
        cyc(4);
        chk("e_valid_pre", pkt_valid, 1'b1);
        wait_edges(59, 400);
        cyc(5);
        @(negedge clk_pixel);
        rate_sel = 2'd1;
        cyc(1);
        chk("e_valid_clr", pkt_valid, 1'b0);
        chk("e_locked_clr", locked, 1'b0);
        base = aud_edges;
        wait_edges(49, 2000);
        cyc(4);
        chk("e_valid_early", pkt_valid, 1'b0);
        wait_edges(50, 200);
        cyc(4);
        chk("e_valid", pkt_valid, 1'b1);
        chk("e_sub", sub, rep4(mk_sub(6272, 980)));
        chk("e_overrun", overrun, 1'b0);

        // 12-bit CTS saturation, true count 9600
        do_reset(2'd2);
        aud_per = 200;
        wait_edges(49, 12000);
        cyc(4);
        chk("g_valid12", pkt_valid12, 1'b1);
        chk("g_locked12", locked12, 1'b1);
        chk("g_sub12", sub12, rep4(mk_sub(6144, 4095)));
        chk("g_header12", header12, 24'h000001);
        chk("g_overrun12", overrun12, 1'b0);
        chk("g_sub20", sub, rep4(mk_sub(6144, 9600)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
